// File: rtl/arbitro_balance_if.sv
// rtl/arbitro_balance_if.sv - request/response bundle between ATM controllers and the balance arbiter
// Signals:
//   REQ[N_REQ]        level request per controller, held until its DONE
//   TIPO[N_REQ]       1 = withdrawal (retiro), 0 = deposit
//   MONTO[N_REQ*W]    amount, controller i uses [i*W +: W]
//   GNT[N_REQ]        one-hot grant
//   DONE[N_REQ]       one-hot single-cycle completion pulse
//   RES_OK / RES_FONDOS / RES_DESBORDE  outcome flags, valid with DONE
//   BALANCE[W]        committed balance
//   BUSY              arbiter not idle
// Modports: master = controller side, slave = arbiter side.
interface arbitro_balance_if #(
   parameter int N_REQ = 2,
   parameter int W     = 32
);
   logic [N_REQ-1:0]   REQ;
   logic [N_REQ-1:0]   TIPO;
   logic [N_REQ*W-1:0] MONTO;
   logic [N_REQ-1:0]   GNT;
   logic [N_REQ-1:0]   DONE;
   logic               RES_OK;
   logic               RES_FONDOS;
   logic               RES_DESBORDE;
   logic [W-1:0]       BALANCE;
   logic               BUSY;

   modport master (
      output REQ, TIPO, MONTO,
      input  GNT, DONE, RES_OK, RES_FONDOS, RES_DESBORDE, BALANCE, BUSY
   );

   modport slave (
      input  REQ, TIPO, MONTO,
      output GNT, DONE, RES_OK, RES_FONDOS, RES_DESBORDE, BALANCE, BUSY
   );
endinterface

// File: rtl/arbitro_balance.sv
// rtl/arbitro_balance.sv - round-robin arbiter and sequencer for a shared account balance
// Ports:
//   CLK    clock, rising edge
//   RESET  synchronous, active-high
//   bus    arbitro_balance_if.slave (REQ/TIPO/MONTO in; GNT/DONE/RES_*/BALANCE/BUSY out)
// One transaction per three cycles at best: IDLE (grant) -> EXEC (update) -> RESP (DONE pulse).
module arbitro_balance #(
   parameter int             N_REQ        = 2,
   parameter int             W            = 32,
   parameter logic [W-1:0]   BALANCE_INIT = W'(5000)
) (
   input  logic              CLK,
   input  logic              RESET,
   arbitro_balance_if.slave  bus
);

   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t          state;
   logic [IW-1:0]   ptr;       // last granted requester
   logic            tipo_q;
   logic [W-1:0]    monto_q;

   logic [IW-1:0]   sel;
   logic            any_req;
   logic [W:0]      sum;
   int              j;

   // Scan ptr+1, ptr+2, ... wrapping at N_REQ; first asserted request wins.
   always_comb begin
      sel     = ptr;
      any_req = 1'b0;
      j       = 0;
      for (int k = 1; k <= N_REQ; k++) begin
         j = int'(ptr) + k;
         if (j >= N_REQ) j = j - N_REQ;
         if (!any_req && bus.REQ[j]) begin
            any_req = 1'b1;
            sel     = j[IW-1:0];
         end
      end
   end

   // One extra bit so a deposit that wraps W bits is detectable.
   assign sum = {1'b0, bus.BALANCE} + {1'b0, monto_q};

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state            <= IDLE;
         ptr              <= IW'(N_REQ - 1);
         tipo_q           <= 1'b0;
         monto_q          <= '0;
         bus.BALANCE      <= BALANCE_INIT;
         bus.GNT          <= '0;
         bus.DONE         <= '0;
         bus.RES_OK       <= 1'b0;
         bus.RES_FONDOS   <= 1'b0;
         bus.RES_DESBORDE <= 1'b0;
         bus.BUSY         <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  ptr      <= sel;
                  tipo_q   <= bus.TIPO[sel];
                  monto_q  <= bus.MONTO[int'(sel)*W +: W];
                  bus.GNT  <= N_REQ'(1) << sel;
                  bus.BUSY <= 1'b1;
                  state    <= EXEC;
               end
            end
            EXEC: begin
               // GNT is already one-hot on the winner, so it doubles as the DONE pattern.
               bus.DONE <= bus.GNT;
               state    <= RESP;
               if (tipo_q) begin
                  if (monto_q <= bus.BALANCE) begin
                     bus.BALANCE <= bus.BALANCE - monto_q;
                     bus.RES_OK  <= 1'b1;
                  end else begin
                     bus.RES_FONDOS <= 1'b1;
                  end
               end else begin
                  if (sum[W]) begin
                     bus.RES_DESBORDE <= 1'b1;
                  end else begin
                     bus.BALANCE <= sum[W-1:0];
                     bus.RES_OK  <= 1'b1;
                  end
               end
            end
            RESP: begin
               bus.GNT          <= '0;
               bus.DONE         <= '0;
               bus.RES_OK       <= 1'b0;
               bus.RES_FONDOS   <= 1'b0;
               bus.RES_DESBORDE <= 1'b0;
               bus.BUSY         <= 1'b0;
               state            <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
